// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: byte-serial controller between the load buffer / store-commit
// path and an 8-bit RAM port. One load or store at a time, 1-4 byte cycles.
// Optional feature macro: RAM_BUS_FLUSH_ABORT_EN (flush aborts an in-flight
// load immediately instead of letting it drain with its result suppressed).
//
// Handshake: a request is taken at a rising edge where the controller is IDLE
// and rdy_in=1. A store is taken whenever store_en_in=1; a load is taken only
// when load_rdy_out=1 and load_en_in=1. Requesters hold their inputs until
// taken. Results come back as one-cycle registered pulses.
module ram_bus_ctrl #(
  parameter int ROB_W   = 4,
  parameter int TYPE_W  = 6,
  parameter int TYPE_LB  = 1,
  parameter int TYPE_LH  = 2,
  parameter int TYPE_LW  = 3,
  parameter int TYPE_LBU = 4,
  parameter int TYPE_LHU = 5,
  parameter int TYPE_SB  = 6,
  parameter int TYPE_SH  = 7,
  parameter int TYPE_SW  = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_flush_in,
  input  logic              load_en_in,
  input  logic [31:0]       load_A_in,
  input  logic [ROB_W-1:0]  load_dest_in,
  input  logic [TYPE_W-1:0] load_inst_type_in,
  output logic              load_rdy_out,
  output logic              load_data_en_out,
  output logic [31:0]       load_data_out,
  input  logic              store_en_in,
  input  logic [31:0]       store_A_in,
  input  logic [31:0]       store_data_in,
  input  logic [TYPE_W-1:0] store_inst_type_in,
  output logic              store_done_out,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr,
  output logic [1:0]        dbg_state_out,
  output logic [ROB_W-1:0]  dbg_load_dest_out
);

  localparam logic [TYPE_W-1:0] T_LB  = TYPE_W'(TYPE_LB);
  localparam logic [TYPE_W-1:0] T_LH  = TYPE_W'(TYPE_LH);
  localparam logic [TYPE_W-1:0] T_LBU = TYPE_W'(TYPE_LBU);
  localparam logic [TYPE_W-1:0] T_LHU = TYPE_W'(TYPE_LHU);
  localparam logic [TYPE_W-1:0] T_SB  = TYPE_W'(TYPE_SB);
  localparam logic [TYPE_W-1:0] T_SH  = TYPE_W'(TYPE_SH);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_STORE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         nbytes_q, nbytes_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [TYPE_W-1:0]  type_q, type_d;
  logic [31:0]        asm_q, asm_d;
  logic               killed_q, killed_d;
  logic [ROB_W-1:0]   dest_q, dest_d;
  logic               load_en_q, load_en_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               store_done_q, store_done_d;
  logic [1:0]         byte_idx;

  // Word/half/byte size from the instruction type; anything else is a word.
  function automatic logic [2:0] byte_count(input logic [TYPE_W-1:0] t);
    if (t == T_LB || t == T_LBU || t == T_SB) return 3'd1;
    else if (t == T_LH || t == T_LHU || t == T_SH) return 3'd2;
    else return 3'd4;
  endfunction

  // Sign/zero extension of the assembled little-endian value.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [TYPE_W-1:0] t);
    logic [31:0] r;
    r = raw;
    if (t == T_LB)       r = {{24{raw[7]}}, raw[7:0]};
    else if (t == T_LH)  r = {{16{raw[15]}}, raw[15:0]};
    else if (t == T_LBU) r = {24'd0, raw[7:0]};
    else if (t == T_LHU) r = {16'd0, raw[15:0]};
    return r;
  endfunction

  // Next-state, byte sequencing, assembly and result pulses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nbytes_d     = nbytes_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    type_d       = type_q;
    asm_d        = asm_q;
    killed_d     = killed_q;
    dest_d       = dest_q;
    load_en_d    = 1'b0;
    load_data_d  = load_data_q;
    store_done_d = 1'b0;
    // Byte k read in cycle k+1 arrives while the counter already reads k+1.
    byte_idx     = cnt_q[1:0] - 2'd1;
    if (rdy_in) begin
      case (state_q)
        ST_IDLE: begin
          if (store_en_in) begin
            state_d  = ST_STORE;
            cnt_d    = 3'd0;
            addr_d   = store_A_in;
            wdata_d  = store_data_in;
            nbytes_d = byte_count(store_inst_type_in);
          end else if (load_en_in && !rob_flush_in) begin
            state_d  = ST_LOAD;
            cnt_d    = 3'd0;
            addr_d   = load_A_in;
            type_d   = load_inst_type_in;
            nbytes_d = byte_count(load_inst_type_in);
            asm_d    = 32'd0;
            killed_d = 1'b0;
            dest_d   = load_dest_in;
          end
        end
        ST_LOAD: begin
`ifdef RAM_BUS_FLUSH_ABORT_EN
          if (rob_flush_in) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end else begin
`else
          begin
`endif
            killed_d = killed_q | rob_flush_in;
            if (cnt_q != 3'd0) asm_d[{byte_idx, 3'b000} +: 8] = mem_din;
            if (cnt_q == nbytes_q) begin
              state_d  = ST_IDLE;
              cnt_d    = 3'd0;
              killed_d = 1'b0;
              if (!(killed_q || rob_flush_in)) begin
                load_en_d   = 1'b1;
                load_data_d = extend_load(asm_d, type_q);
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        ST_STORE: begin
          if (cnt_q == nbytes_q - 3'd1) begin
            state_d      = ST_IDLE;
            cnt_d        = 3'd0;
            store_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // State and datapath registers; reset returns everything to IDLE at once.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      nbytes_q     <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      type_q       <= '0;
      asm_q        <= 32'd0;
      killed_q     <= 1'b0;
      dest_q       <= '0;
      load_en_q    <= 1'b0;
      load_data_q  <= 32'd0;
      store_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nbytes_q     <= nbytes_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      type_q       <= type_d;
      asm_q        <= asm_d;
      killed_q     <= killed_d;
      dest_q       <= dest_d;
      load_en_q    <= load_en_d;
      load_data_q  <= load_data_d;
      store_done_q <= store_done_d;
    end
  end

  // RAM port drive: address/data from the byte counter, writes gated by rdy_in.
  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    mem_wr   = 1'b0;
    if (state_q == ST_STORE) begin
      mem_a    = addr_q + {29'd0, cnt_q};
      mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      mem_wr   = rdy_in;
    end else if (state_q == ST_LOAD && cnt_q != nbytes_q) begin
      mem_a = addr_q + {29'd0, cnt_q};
    end
  end

  assign load_rdy_out      = rst_in && (state_q == ST_IDLE) && !store_en_in && !rob_flush_in;
  assign load_data_en_out  = load_en_q;
  assign load_data_out     = load_data_q;
  assign store_done_out    = store_done_q;
  assign dbg_state_out     = state_q;
  assign dbg_load_dest_out = dest_q;

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// tb_ram_bus_ctrl: self-checking bench for ram_bus_ctrl with a byte RAM model
// and a reference model of memory contents and load results.
module tb_ram_bus_ctrl;

  localparam logic [5:0] LB = 6'd1, LH = 6'd2, LW = 6'd3, LBU = 6'd4, LHU = 6'd5;
  localparam logic [5:0] SB = 6'd6, SH = 6'd7, SW = 6'd8;

  logic        clk_in, rst_in, rdy_in, rob_flush_in;
  logic        load_en_in, load_rdy_out, load_data_en_out;
  logic [31:0] load_A_in, load_data_out;
  logic [3:0]  load_dest_in, dbg_load_dest_out;
  logic [5:0]  load_inst_type_in, store_inst_type_in;
  logic        store_en_in, store_done_out;
  logic [31:0] store_A_in, store_data_in;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [1:0]  dbg_state_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  logic [7:0] ram     [0:4095];
  logic [7:0] exp_mem [0:4095];

  ram_bus_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_flush_in(rob_flush_in),
    .load_en_in(load_en_in), .load_A_in(load_A_in), .load_dest_in(load_dest_in),
    .load_inst_type_in(load_inst_type_in), .load_rdy_out(load_rdy_out),
    .load_data_en_out(load_data_en_out), .load_data_out(load_data_out),
    .store_en_in(store_en_in), .store_A_in(store_A_in), .store_data_in(store_data_in),
    .store_inst_type_in(store_inst_type_in), .store_done_out(store_done_out),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .dbg_state_out(dbg_state_out), .dbg_load_dest_out(dbg_load_dest_out)
  );

  // Clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
      exp_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    end
  end

  // RAM: one-cycle read latency, holds mem_din while rdy_in is low.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    end
  end

  // Reference model
  function automatic int nb(input logic [5:0] t);
    if (t == LB || t == LBU || t == SB) return 1;
    if (t == LH || t == LHU || t == SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] t, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] ak;
    v = 0;
    for (int k = 0; k < nb(t); k++) begin
      ak = a + 32'(k);
      v = v + ({24'd0, exp_mem[ak[11:0]]} << (8 * k));
    end
    if (t == LB && v >= 32'd128)   v = v + 32'hFFFFFF00;
    if (t == LH && v >= 32'd32768) v = v + 32'hFFFF0000;
    return v;
  endfunction

  task automatic ref_store(input logic [5:0] t, input logic [31:0] a, input logic [31:0] d,
                           input int upto);
    logic [31:0] ak;
    for (int k = 0; k < nb(t) && k < upto; k++) begin
      ak = a + 32'(k);
      exp_mem[ak[11:0]] = 8'(d >> (8 * k));
    end
  endtask

  task automatic check_mem(input string nm, input logic [31:0] a);
    logic [31:0] ak;
    for (int k = 0; k < 5; k++) begin
      ak = a + 32'(k);
      checks++;
      if (ram[ak[11:0]] !== exp_mem[ak[11:0]]) begin
        errors++;
        $display("FAIL %s mem[%h] got %h exp %h", nm, ak, ram[ak[11:0]], exp_mem[ak[11:0]]);
      end
    end
  endtask

  // Driver tasks
  task automatic do_load(input logic [5:0] t, input logic [31:0] a);
    int n;
    bit got;
    logic [31:0] e;
    n = nb(t);
    @(negedge clk_in);
    checks++;
    if (load_rdy_out !== 1'b1) begin
      errors++; $display("FAIL load_rdy_before got %b exp 1", load_rdy_out);
    end
    load_en_in = 1; load_A_in = a; load_inst_type_in = t;
    load_dest_in = 4'($urandom_range(0, 15));
    exp_q.push_back(ref_load(t, a));
    @(posedge clk_in);
    #1 load_en_in = 0;
    got = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk_in);
      if (c <= n) begin
        checks++;
        if (mem_a !== a + 32'(c - 1) || mem_wr !== 1'b0) begin
          errors++;
          $display("FAIL load_addr cycle %0d got a=%h wr=%b exp a=%h wr=0", c, mem_a, mem_wr, a + 32'(c - 1));
        end
      end
      if (load_data_en_out === 1'b1) begin
        got = 1;
        e = exp_q.pop_front();
        checks++;
        if (c != n + 2) begin errors++; $display("FAIL load_latency got %0d exp %0d", c, n + 2); end
        checks++;
        if (load_data_out !== e) begin
          errors++; $display("FAIL load_data a=%h t=%0d got %h exp %h", a, t, load_data_out, e);
        end
        checks++;
        if (load_rdy_out !== 1'b1) begin errors++; $display("FAIL load_rdy_at_pulse got %b exp 1", load_rdy_out); end
      end
    end
    if (!got) begin
      checks++; errors++; void'(exp_q.pop_front());
      $display("FAIL load_timeout a=%h got no pulse exp pulse", a);
    end
  endtask

  task automatic do_store(input logic [5:0] t, input logic [31:0] a, input logic [31:0] d);
    int n;
    int done_c;
    n = nb(t);
    done_c = 0;
    @(negedge clk_in);
    store_en_in = 1; store_A_in = a; store_data_in = d; store_inst_type_in = t;
    ref_store(t, a, d, 4);
    @(posedge clk_in);
    #1 store_en_in = 0;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk_in);
      if (c <= n) begin
        checks++;
        if (mem_wr !== 1'b1 || mem_a !== a + 32'(c - 1) || mem_dout !== 8'(d >> (8 * (c - 1)))) begin
          errors++;
          $display("FAIL store_cycle %0d got wr=%b a=%h d=%h exp wr=1 a=%h d=%h", c, mem_wr, mem_a,
                   mem_dout, a + 32'(c - 1), 8'(d >> (8 * (c - 1))));
        end
      end
      if (store_done_out === 1'b1) done_c = c;
    end
    checks++;
    if (done_c != n + 1) begin errors++; $display("FAIL store_done_cycle got %0d exp %0d", done_c, n + 1); end
    check_mem("store", a);
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst_in = 0; rdy_in = 1; rob_flush_in = 0; load_en_in = 0; store_en_in = 0;
    load_A_in = 0; load_dest_in = 0; load_inst_type_in = 0;
    store_A_in = 0; store_data_in = 0; store_inst_type_in = 0;
    repeat (2) @(negedge clk_in);
    checks++;
    if ({mem_wr, mem_a, mem_dout, load_rdy_out, load_data_en_out, load_data_out, store_done_out} !== '0) begin
      errors++; $display("FAIL reset_outputs got wr=%b a=%h rdy=%b exp all zero", mem_wr, mem_a, load_rdy_out);
    end
    rst_in = 1;
    @(negedge clk_in);
    checks++;
    if (load_rdy_out !== 1'b1) begin errors++; $display("FAIL reset_release_rdy got %b exp 1", load_rdy_out); end
  endtask

  task automatic test_lb_sign();
    ram[12'h104] = 8'h80; exp_mem[12'h104] = 8'h80;
    do_load(LB, 32'h104);
    do_load(LBU, 32'h104);
    checks++;
    if (load_data_out !== 32'h00000080) begin errors++; $display("FAIL lbu_value got %h exp 00000080", load_data_out); end
  endtask

  task automatic test_lw_unaligned();
    logic [7:0] b [4];
    logic [31:0] a;
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      a = 32'h1FFFFFFF + 32'(k);
      ram[a[11:0]] = b[k]; exp_mem[a[11:0]] = b[k];
    end
    do_load(LW, 32'h1FFFFFFF);
    checks++;
    if (load_data_out !== 32'h44332211) begin errors++; $display("FAIL lw_unaligned got %h exp 44332211", load_data_out); end
  endtask

  task automatic test_sh();
    do_store(SH, 32'h200, 32'hDEADBEEF);
  endtask

  task automatic test_random();
    logic [5:0] types [8];
    logic [5:0] t;
    logic [31:0] a;
    types = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    for (int i = 0; i < 40; i++) begin
      t = types[$urandom_range(0, 7)];
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                      : 32'h300 + 32'($urandom_range(0, 15));
      if (t >= SB) do_store(t, a, $urandom);
      else do_load(t, a);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] e;
    int done_c;
    bit got;
    d = $urandom;
    done_c = 0;
    @(negedge clk_in);
    store_en_in = 1; store_A_in = 32'h400; store_data_in = d; store_inst_type_in = SW;
    load_en_in = 1; load_A_in = 32'h400; load_inst_type_in = LW;
    ref_store(SW, 32'h400, d, 4);
    #1;
    checks++;
    if (load_rdy_out !== 1'b0) begin errors++; $display("FAIL collide_rdy0 got %b exp 0", load_rdy_out); end
    @(posedge clk_in);
    #1 store_en_in = 0;
    for (int c = 1; c <= 12 && done_c == 0; c++) begin
      @(negedge clk_in);
      checks++;
      if (store_done_out === 1'b1) begin
        done_c = c;
        if (load_rdy_out !== 1'b1) begin errors++; $display("FAIL collide_rdy_at_done got %b exp 1", load_rdy_out); end
      end else if (load_rdy_out !== 1'b0) begin
        errors++; $display("FAIL collide_rdy_busy cycle %0d got %b exp 0", c, load_rdy_out);
      end
    end
    checks++;
    if (done_c != 5) begin errors++; $display("FAIL collide_done_cycle got %0d exp 5", done_c); end
    exp_q.push_back(ref_load(LW, 32'h400));
    @(posedge clk_in);
    #1 load_en_in = 0;
    got = 0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk_in);
      if (load_data_en_out === 1'b1) begin
        got = 1;
        e = exp_q.pop_front();
        checks++;
        if (load_data_out !== e) begin errors++; $display("FAIL collide_load got %h exp %h", load_data_out, e); end
      end
    end
    if (!got) begin checks++; errors++; void'(exp_q.pop_front()); $display("FAIL collide_load_timeout got none exp pulse"); end
  endtask

  task automatic test_flush();
    int pulses;
    pulses = 0;
    @(negedge clk_in);
    load_en_in = 1; load_A_in = 32'h500; load_inst_type_in = LW;
    @(posedge clk_in);
    #1 load_en_in = 0;
    @(negedge clk_in);
    @(negedge clk_in);
    rob_flush_in = 1;
    @(negedge clk_in);
    rob_flush_in = 0;
    #1;
    checks++;
`ifdef RAM_BUS_FLUSH_ABORT_EN
    if (load_rdy_out !== 1'b1 || mem_a !== 32'd0) begin
      errors++; $display("FAIL flush_abort got rdy=%b a=%h exp rdy=1 a=0", load_rdy_out, mem_a);
    end
`else
    if (mem_a !== 32'h502) begin errors++; $display("FAIL flush_walk2 got %h exp 00000502", mem_a); end
    @(negedge clk_in);
    checks++;
    if (mem_a !== 32'h503) begin errors++; $display("FAIL flush_walk3 got %h exp 00000503", mem_a); end
`endif
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_in);
      if (load_data_en_out === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL flush_pulse got %0d exp 0", pulses); end
    do_load(LW, 32'h500);
  endtask

  task automatic test_stall();
    logic [31:0] d;
    logic [31:0] e;
    int done_n;
    bit got;
    d = $urandom;
    done_n = 0;
    @(negedge clk_in);
    store_en_in = 1; store_A_in = 32'h700; store_data_in = d; store_inst_type_in = SW;
    ref_store(SW, 32'h700, d, 4);
    @(posedge clk_in);
    #1 store_en_in = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_in);
      if (store_done_out === 1'b1) done_n++;
      rdy_in = ($urandom_range(0, 2) != 0);
      #1;
      if (!rdy_in) begin
        checks++;
        if (mem_wr !== 1'b0) begin errors++; $display("FAIL stall_wr_gate got %b exp 0", mem_wr); end
      end
    end
    rdy_in = 1;
    @(negedge clk_in);
    checks++;
    if (done_n != 1) begin errors++; $display("FAIL stall_store_done got %0d exp 1", done_n); end
    check_mem("stall", 32'h700);
    load_en_in = 1; load_A_in = 32'h700; load_inst_type_in = LW;
    exp_q.push_back(ref_load(LW, 32'h700));
    @(posedge clk_in);
    #1 load_en_in = 0;
    got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk_in);
      if (load_data_en_out === 1'b1) begin
        got = 1;
        e = exp_q.pop_front();
        checks++;
        if (load_data_out !== e) begin errors++; $display("FAIL stall_load got %h exp %h", load_data_out, e); end
      end else begin
        rdy_in = ($urandom_range(0, 2) != 0);
      end
    end
    rdy_in = 1;
    if (!got) begin checks++; errors++; void'(exp_q.pop_front()); $display("FAIL stall_load_timeout got none exp pulse"); end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] d;
    d = $urandom;
    @(negedge clk_in);
    store_en_in = 1; store_A_in = 32'h600; store_data_in = d; store_inst_type_in = SW;
    ref_store(SW, 32'h600, d, 2);
    @(posedge clk_in);
    #1 store_en_in = 0;
    repeat (3) @(negedge clk_in);
    rst_in = 0;
    #1;
    checks++;
    if (mem_wr !== 1'b0 || mem_a !== 32'd0 || load_rdy_out !== 1'b0) begin
      errors++; $display("FAIL mid_reset got wr=%b a=%h rdy=%b exp 0 0 0", mem_wr, mem_a, load_rdy_out);
    end
    @(negedge clk_in);
    rst_in = 1;
    @(negedge clk_in);
    checks++;
    if (load_rdy_out !== 1'b1) begin errors++; $display("FAIL mid_reset_rdy got %b exp 1", load_rdy_out); end
    check_mem("mid_reset", 32'h600);
  endtask

  initial begin
    test_reset();
    test_lb_sign();
    test_lw_unaligned();
    test_sh();
    test_random();
    test_back_to_back();
    test_flush();
    test_stall();
    test_reset_mid_store();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
